// File: rtl/uart_word_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_word_loader
//
// Parses a framed program image arriving as a UART byte stream and writes it
// into instruction/data memory as little-endian words of WORD_BYTES bytes.
//
// Frame: SYNC_BYTE, word count N (16-bit, LSB first), N*WORD_BYTES payload
// bytes, then one XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// The checksum is the XOR of both length bytes and every payload byte.
//
// Build option:
//   LOADER_CHECKSUM_EN  defined   -> trailing checksum byte required; a
//                                    mismatch ends the frame in error.
//                       undefined -> no checksum; the frame ends on the last
//                                    payload byte.
//
// Ports:
//   clk_10MHz     in   system clock
//   rst_n         in   asynchronous active-low reset
//   rx_data[7:0]  in   received byte, qualified by rx_valid
//   rx_valid      in   one-cycle strobe per received byte
//   mem_we        out  one-cycle registered write strobe
//   mem_addr      out  byte address of the word written (words * WORD_BYTES)
//   mem_wdata     out  assembled word, first received byte in the LSB
//   busy          out  frame in progress
//   load_done     out  last frame completed cleanly (held until next sync)
//   load_err      out  last frame aborted: capacity, timeout or checksum
//   words_loaded  out  words written in the current or last frame
// -----------------------------------------------------------------------------
module uart_word_loader #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                    clk_10MHz,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err,
    output logic [15:0]             words_loaded
);

    localparam int unsigned WORD_W  = 8 * WORD_BYTES;
    localparam int unsigned LANE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);

    // Largest word count that fits the byte-addressed memory.
    localparam longint unsigned MAX_WORDS = (64'd1 << ADDR_W) / WORD_BYTES;

    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(WORD_BYTES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK  = 3'd4;
    // Where the frame goes once the payload (or an empty payload) is complete.
    localparam logic [2:0] PAYLOAD_END = CHECK;
`else
    localparam logic [2:0] PAYLOAD_END = DONE;
`endif

    logic [2:0]         state_q,     state_d;
    logic [15:0]        len_q,       len_d;
    logic [15:0]        words_q,     words_d;
    logic [LANE_W-1:0]  lane_q,      lane_d;
    logic [WORD_W-1:0]  word_q,      word_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q,      csum_d;
`endif

    logic               in_frame;
    logic [15:0]        len_rx;
    logic [WORD_W-1:0]  word_ins;

`ifdef LOADER_CHECKSUM_EN
    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CHECK);
`else
    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA);
`endif

    // Full word count as it would be latched by the byte now on rx_data.
    assign len_rx = {rx_data, len_q[7:0]};

    // Current word with the incoming byte placed in lane lane_q.
    always_comb begin
        word_ins = word_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane_q == LANE_W'(i)) word_ins[8*i +: 8] = rx_data;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        lane_d      = lane_q;
        word_d      = word_q;
        timer_d     = timer_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = LEN_LO;
                    words_d = '0;
                    lane_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                end
            end

            LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_rx;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (64'(len_rx) > MAX_WORDS) state_d = ERROR;
                    else if (len_rx == 16'd0)    state_d = PAYLOAD_END;
                    else                         state_d = DATA;
                end
            end

            DATA: begin
                if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    word_d = word_ins;
                    if (lane_q == LAST_LANE) begin
                        lane_d      = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(64'(words_q) * 64'(WORD_BYTES));
                        mem_wdata_d = word_ins;
                        words_d     = words_q + 16'd1;
                        if ((words_q + 16'd1) == len_q) state_d = PAYLOAD_END;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) state_d = (rx_data == csum_q) ? DONE : ERROR;
            end
`endif

            default: state_d = IDLE;
        endcase

        // Idle-gap watchdog. The error fires on the TIMEOUT_CYC-th consecutive
        // idle cycle; a byte arriving in that cycle clears the count instead.
        if (!in_frame || rx_valid) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            state_d = ERROR;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_10MHz or negedge rst_n) begin
        // NOTE: the word and write-data registers are reset along with the
        // control state so mem_wdata reads 0 out of reset rather than X.
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            words_q     <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            timer_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            timer_q     <= timer_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = in_frame;
    assign load_done    = (state_q == DONE);
    assign load_err     = (state_q == ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_word_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_word_loader
//
// Self-checking bench for uart_word_loader (WORD_BYTES=4, ADDR_W=8, short
// TIMEOUT_CYC). Directed frames come from a vector table; randomized frames
// are checked against a frame-level model that derives the expected writes
// and final status directly from the framing rules. Adapts to whether
// LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_word_loader;

    localparam int         WB   = 4;
    localparam int         AW   = 8;
    localparam int         TO   = 20;
    localparam int         CAP  = (1 << AW) / WB;
    localparam logic [7:0] SYNC = 8'hA5;

    logic          clk_10MHz = 1'b0;
    logic          rst_n     = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic          rx_valid  = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          load_done;
    logic          load_err;
    logic [15:0]   words_loaded;

    always #50 clk_10MHz = ~clk_10MHz;

    uart_word_loader #(
        .WORD_BYTES (WB),
        .ADDR_W     (AW),
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_10MHz   (clk_10MHz),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    logic       prev_we = 1'b0;

    // Write monitor: collects every write and confirms the strobe is one cycle.
    always @(negedge clk_10MHz) begin
        if (mem_we) begin
            check("we_single_cycle", 64'(prev_we), 64'd0);
            got_q.push_back({mem_addr, mem_wdata});
        end
        prev_we <= mem_we;
    end

    // Inputs change on the falling edge; outputs are read on the falling edge.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk_10MHz);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic send_tx(input int max_gap);
        foreach (tx_q[i]) begin
            idle($urandom_range(0, max_gap));
            step(1'b1, tx_q[i]);
        end
        tx_q.delete();
    endtask

    task automatic finish_frame(input string name, input logic done, input logic err,
                                input int words);
        check({name, "_done"},   64'(load_done), 64'(done));
        check({name, "_err"},    64'(load_err),  64'(err));
        check({name, "_busy"},   64'(busy),      64'd0);
        check({name, "_words"},  64'(words_loaded), 64'(words));
        check({name, "_nwrite"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({name, "_waddr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
            check({name, "_wdata"}, 64'(got_q[i].data), 64'(exp_q[i].data));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Directed frame vectors: bytes are right-aligned, first byte most significant.
    typedef struct {
        string       name;
        int          nb;
        logic [95:0] bytes;
        int          tail;
        logic [1:0]  res_sum;   // {load_done, load_err} with checksum built in
        logic [1:0]  res_nosum; // {load_done, load_err} without checksum
        int          words;
        int          nwr;
        wr_t         w0;
        wr_t         w1;
    } vec_t;

    vec_t vecs[6];

    // Frame-level reference: expected writes and outcome from the framing rules.
    task automatic random_frame(input int idx);
        int         n, p, mode, tail, words;
        logic [7:0] payload[$];
        logic [7:0] csum, junk, b;
        logic       exp_done, exp_err;
        string      name;
        name     = $sformatf("rand%0d", idx);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        tail     = 2;
        n = $urandom_range(0, 70);
        if ($urandom_range(0, 9) == 0) n = CAP;
        if ($urandom_range(0, 1) == 1) begin
            do junk = 8'($urandom); while (junk == SYNC);
            tx_q.push_back(junk);
        end
        tx_q.push_back(SYNC);
        tx_q.push_back(8'(n));
        tx_q.push_back(8'(n >> 8));
        if (n > CAP) begin
            send_tx(2);
            idle(tail);
            finish_frame(name, 1'b0, 1'b1, 0);
            return;
        end
        mode = $urandom_range(0, 3);
        p = WB * n;
        if (mode == 0 && n > 0) p = $urandom_range(0, WB * n - 1);
        csum = 8'(n) ^ 8'(n >> 8);
        for (int i = 0; i < p; i++) begin
            b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
            payload.push_back(b);
            tx_q.push_back(b);
            csum ^= b;
        end
        words = p / WB;
        for (int i = 0; i < words; i++) begin
            exp_q.push_back({8'(WB * i), payload[WB*i+3], payload[WB*i+2],
                             payload[WB*i+1], payload[WB*i]});
        end
        if (p < WB * n) begin
            exp_err = 1'b1;
            tail    = TO + 1;
        end else begin
`ifdef LOADER_CHECKSUM_EN
            if (mode == 1) begin
                tx_q.push_back(csum ^ 8'($urandom_range(1, 255)));
                exp_err = 1'b1;
            end else begin
                tx_q.push_back(csum);
                exp_done = 1'b1;
            end
`else
            exp_done = 1'b1;
`endif
        end
        send_tx(2);
        idle(tail);
        finish_frame(name, exp_done, exp_err, words);
    endtask

    initial begin
        vecs[0] = '{"good", 12, 96'hA5_02_00_13_00_50_00_93_00_00_00_D2, 2, 2'b10, 2'b10,
                    2, 2, {8'h00, 32'h00500013}, {8'h04, 32'h00000093}};
        vecs[1] = '{"badsum", 12, 96'hA5_02_00_13_00_50_00_93_00_00_00_00, 2, 2'b01, 2'b10,
                    2, 2, {8'h00, 32'h00500013}, {8'h04, 32'h00000093}};
        vecs[2] = '{"capacity", 3, 96'hA5_41_00, 2, 2'b01, 2'b01, 0, 0, '0, '0};
        vecs[3] = '{"empty", 4, 96'hA5_00_00_00, 2, 2'b10, 2'b10, 0, 0, '0, '0};
        vecs[4] = '{"timeout", 4, 96'hA5_01_00_13, TO, 2'b01, 2'b01, 0, 0, '0, '0};
        vecs[5] = '{"sync_in_data", 8, 96'hA5_01_00_A5_11_22_33_A4, 2, 2'b10, 2'b10,
                    1, 1, {8'h00, 32'h332211A5}, '0};

        // Reset held with random traffic: every output stays at zero.
        @(negedge clk_10MHz);
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom), (i % 2 == 0) ? SYNC : 8'($urandom));
            check("reset_outputs",
                  {4'd0, mem_we, mem_addr, mem_wdata, busy, load_done, load_err, words_loaded},
                  64'd0);
        end
        rst_n = 1'b1;
        idle(2);
        got_q.delete();

        // Directed table, bytes sent back-to-back.
        foreach (vecs[k]) begin
            logic [1:0] res;
`ifdef LOADER_CHECKSUM_EN
            res = vecs[k].res_sum;
`else
            res = vecs[k].res_nosum;
`endif
            for (int i = 0; i < vecs[k].nb; i++)
                tx_q.push_back(vecs[k].bytes[8*(vecs[k].nb-1-i) +: 8]);
            if (vecs[k].nwr > 0) exp_q.push_back(vecs[k].w0);
            if (vecs[k].nwr > 1) exp_q.push_back(vecs[k].w1);
            send_tx(0);
            idle(vecs[k].tail);
            finish_frame(vecs[k].name, res[1], res[0], vecs[k].words);
        end

        // A byte landing on the expiry cycle wins over the timeout.
        tx_q = '{SYNC, 8'h01, 8'h00, 8'h13};
        send_tx(0);
        idle(TO - 1);
        check("expiry_busy", 64'(busy), 64'd1);
        check("expiry_err",  64'(load_err), 64'd0);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
`ifdef LOADER_CHECKSUM_EN
        step(1'b1, 8'h12);
`endif
        idle(2);
        exp_q.push_back({8'h00, 32'h00000013});
        finish_frame("expiry_byte", 1'b1, 1'b0, 1);

        // Reload after DONE clears the flags; reset mid-DATA stops further writes.
        tx_q = '{SYNC, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h00,
                 8'h00, 8'hD2};
        send_tx(0);
        idle(2);
        exp_q = '{{8'h00, 32'h00500013}, {8'h04, 32'h00000093}};
        finish_frame("pre_reload", 1'b1, 1'b0, 2);
        step(1'b1, SYNC);
        check("reload_done",  64'(load_done), 64'd0);
        check("reload_err",   64'(load_err), 64'd0);
        check("reload_words", 64'(words_loaded), 64'd0);
        check("reload_busy",  64'(busy), 64'd1);
        tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_tx(0);
        check("mid_words", 64'(words_loaded), 64'd1);
        rx_valid = 1'b0;
        #10 rst_n = 1'b0;
        @(negedge clk_10MHz);
        check("midreset_outputs",
              {4'd0, mem_we, mem_addr, mem_wdata, busy, load_done, load_err, words_loaded},
              64'd0);
        step(1'b1, 8'h66);
        rst_n = 1'b1;
        tx_q = '{8'h77, 8'h88, 8'h99, 8'h12, 8'h34};
        send_tx(0);
        idle(2);
        exp_q.push_back({8'h00, 32'h44332211});
        finish_frame("after_reset", 1'b0, 1'b0, 0);

        // Randomized frames with random inter-byte gaps.
        for (int i = 0; i < 40; i++) random_frame(i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog: simulation did not complete within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
